// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR datapath with one shared multiplier and one accumulator.
// Each accepted sample runs LOAD, then n MAC cycles, then WRITE, and a one-cycle out_valid pulse follows.
module fir_seq_ctrl #(
    parameter int NTAPS = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W:0]   taps_active,
    input  logic             stall,
    output logic             x_ld,
    output logic             sum_clr,
    output logic             sum_ld,
    output logic [SEL_W-1:0] mult_sel,
    output logic             y_ld,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MAC   = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [SEL_W:0] N_MAX = (SEL_W + 1)'(NTAPS);
    localparam logic [SEL_W:0] N_ONE = (SEL_W + 1)'(1);

    state_t           state;
    logic [SEL_W-1:0] tap;
    logic [SEL_W:0]   n_taps;
    logic [SEL_W:0]   n_clamped;
    logic [SEL_W:0]   n_last;
    logic             last_tap;

    // A tap count of zero still runs one MAC so every sample produces an output.
    always_comb begin
        n_clamped = taps_active;
        if (taps_active == '0) begin
            n_clamped = N_ONE;
        end else if (taps_active > N_MAX) begin
            n_clamped = N_MAX;
        end
    end

    assign n_last   = n_taps - N_ONE;
    assign last_tap = ({1'b0, tap} == n_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tap       <= '0;
            n_taps    <= N_ONE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == WRITE) && !stall;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        n_taps <= n_clamped;
                        tap    <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (!stall) begin
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (!stall) begin
                        if (last_tap) begin
                            tap   <= '0;
                            state <= WRITE;
                        end else begin
                            tap <= tap + SEL_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tap   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall gates the strobes only; state and tap are frozen by the register logic above.
    assign in_ready = (state == IDLE) && !stall;
    assign x_ld     = (state == LOAD) && !stall;
    assign sum_clr  = (state == LOAD) && !stall;
    assign sum_ld   = (state == MAC) && !stall;
    assign y_ld     = (state == WRITE) && !stall;
    assign mult_sel = (state == MAC) ? tap : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: reset, tap-count clamping, back-to-back samples, stall and
// run-time tap changes, each cycle compared against a hand-built output vector.
module tb_fir_seq_ctrl;

    localparam int NTAPS = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W:0]   taps_active;
    logic             stall;
    logic             x_ld;
    logic             sum_clr;
    logic             sum_ld;
    logic [SEL_W-1:0] mult_sel;
    logic             y_ld;
    logic             out_valid;
    logic             busy;

    int assert_count = 0;
    int fail_count   = 0;

    fir_seq_ctrl #(.NTAPS(NTAPS), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .taps_active(taps_active),
        .stall      (stall),
        .x_ld       (x_ld),
        .sum_clr    (sum_clr),
        .sum_ld     (sum_ld),
        .mult_sel   (mult_sel),
        .y_ld       (y_ld),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Vector layout: {in_ready, x_ld, sum_clr, sum_ld, mult_sel[1:0], y_ld, out_valid, busy}
    function automatic logic [8:0] exp_idle(input logic ir, input logic ov);
        return {ir, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ov, 1'b0};
    endfunction

    function automatic logic [8:0] exp_load(input logic st);
        return {1'b0, !st, !st, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [8:0] exp_mac(input logic [1:0] sel, input logic st);
        return {1'b0, 1'b0, 1'b0, !st, sel, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [8:0] exp_write(input logic st);
        return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, !st, 1'b0, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic [SEL_W:0] t);
        in_valid    = v;
        stall       = s;
        taps_active = t;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [8:0] expected);
        logic [8:0] observed;
        observed = {in_ready, x_ld, sum_clr, sum_ld, mult_sel, y_ld, out_valid, busy};
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One full sample starting in an IDLE cycle; returns in the IDLE cycle carrying out_valid.
    task automatic run_sample(input int n_exp, input logic [SEL_W:0] taps_in,
                              input logic [SEL_W:0] taps_mid, input logic hold,
                              input logic ov_first, input string name);
        apply_stimulus(1'b1, 1'b0, taps_in);
        check_output({name, "_accept"}, exp_idle(1'b1, ov_first));
        tick();
        apply_stimulus(hold, 1'b0, taps_mid);
        check_output({name, "_load"}, exp_load(1'b0));
        for (int t = 0; t < n_exp; t++) begin
            tick();
            check_output($sformatf("%s_mac%0d", name, t), exp_mac(2'(t), 1'b0));
        end
        tick();
        check_output({name, "_write"}, exp_write(1'b0));
        tick();
        check_output({name, "_outvalid"}, exp_idle(1'b1, 1'b1));
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        stall       = 1'b0;
        taps_active = 3'd4;
        #1;
        check_output("reset_values", exp_idle(1'b1, 1'b0));
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("after_reset", exp_idle(1'b1, 1'b0));

        $display("[TB] full 4-tap sample");
        run_sample(4, 3'd4, 3'd4, 1'b0, 1'b0, "t2");
        apply_stimulus(1'b0, 1'b0, 3'd4);
        tick();
        check_output("t2_pulse_end", exp_idle(1'b1, 1'b0));

        $display("[TB] reset mid-MAC");
        apply_stimulus(1'b1, 1'b0, 3'd4);
        check_output("t1_accept", exp_idle(1'b1, 1'b0));
        tick();
        apply_stimulus(1'b0, 1'b0, 3'd4);
        check_output("t1_load", exp_load(1'b0));
        tick();
        check_output("t1_mac0", exp_mac(2'd0, 1'b0));
        tick();
        check_output("t1_mac1", exp_mac(2'd1, 1'b0));
        tick();
        check_output("t1_mac2", exp_mac(2'd2, 1'b0));
        reset = 1'b1;
        #1;
        check_output("t1_async_abort", exp_idle(1'b1, 1'b0));
        tick();
        reset = 1'b0;
        #1;
        check_output("t1_held_idle", exp_idle(1'b1, 1'b0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check_output($sformatf("t1_no_output%0d", i), exp_idle(1'b1, 1'b0));
        end

        $display("[TB] run-time tap counts 2, 0, 7");
        run_sample(2, 3'd2, 3'd2, 1'b0, 1'b0, "t3_n2");
        run_sample(1, 3'd0, 3'd0, 1'b0, 1'b1, "t3_n0");
        run_sample(4, 3'd7, 3'd7, 1'b0, 1'b1, "t3_n7");
        apply_stimulus(1'b0, 1'b0, 3'd4);
        tick();
        check_output("t3_end", exp_idle(1'b1, 1'b0));

        $display("[TB] in_valid held high");
        run_sample(4, 3'd4, 3'd4, 1'b1, 1'b0, "t4_a");
        run_sample(4, 3'd4, 3'd4, 1'b1, 1'b1, "t4_b");
        run_sample(4, 3'd4, 3'd4, 1'b1, 1'b1, "t4_c");
        apply_stimulus(1'b0, 1'b0, 3'd4);
        tick();
        check_output("t4_end", exp_idle(1'b1, 1'b0));

        $display("[TB] taps_active change mid-sequence");
        run_sample(4, 3'd4, 3'd2, 1'b0, 1'b0, "t6_a");
        run_sample(2, 3'd2, 3'd2, 1'b0, 1'b1, "t6_b");
        apply_stimulus(1'b0, 1'b0, 3'd4);
        tick();
        check_output("t6_end", exp_idle(1'b1, 1'b0));

        $display("[TB] stall during MAC at tap 1");
        apply_stimulus(1'b1, 1'b0, 3'd4);
        check_output("t5_accept", exp_idle(1'b1, 1'b0));
        tick();
        apply_stimulus(1'b0, 1'b0, 3'd4);
        check_output("t5_load", exp_load(1'b0));
        tick();
        check_output("t5_mac0", exp_mac(2'd0, 1'b0));
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd4);
        check_output("t5_stall0", exp_mac(2'd1, 1'b1));
        tick();
        check_output("t5_stall1", exp_mac(2'd1, 1'b1));
        tick();
        check_output("t5_stall2", exp_mac(2'd1, 1'b1));
        tick();
        apply_stimulus(1'b0, 1'b0, 3'd4);
        check_output("t5_mac1", exp_mac(2'd1, 1'b0));
        tick();
        check_output("t5_mac2", exp_mac(2'd2, 1'b0));
        tick();
        check_output("t5_mac3", exp_mac(2'd3, 1'b0));
        tick();
        check_output("t5_write", exp_write(1'b0));
        tick();
        check_output("t5_outvalid", exp_idle(1'b1, 1'b1));

        $display("[TB] stall in IDLE, LOAD and WRITE");
        apply_stimulus(1'b1, 1'b1, 3'd2);
        check_output("idle_stall", exp_idle(1'b0, 1'b1));
        tick();
        check_output("idle_stall_no_accept", exp_idle(1'b0, 1'b0));
        apply_stimulus(1'b1, 1'b0, 3'd2);
        check_output("ls_accept", exp_idle(1'b1, 1'b0));
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd2);
        check_output("ls_load_stall0", exp_load(1'b1));
        tick();
        check_output("ls_load_stall1", exp_load(1'b1));
        apply_stimulus(1'b0, 1'b0, 3'd2);
        check_output("ls_load", exp_load(1'b0));
        tick();
        check_output("ls_mac0", exp_mac(2'd0, 1'b0));
        tick();
        check_output("ls_mac1", exp_mac(2'd1, 1'b0));
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd2);
        check_output("ls_write_stall0", exp_write(1'b1));
        tick();
        check_output("ls_write_stall1", exp_write(1'b1));
        apply_stimulus(1'b0, 1'b0, 3'd2);
        check_output("ls_write", exp_write(1'b0));
        tick();
        check_output("ls_outvalid", exp_idle(1'b1, 1'b1));
        tick();
        check_output("ls_end", exp_idle(1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
